// File: rtl/execute_div.sv
// Iterative radix-2 restoring divider for the RV64M execute stage.
// Handles DIV/DIVU/REM/REMU and their W forms, with RISC-V divide-by-zero/overflow results.
package execute_div_pkg;
  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_DIV   = 5'd16,
    ALU_REM   = 5'd17,
    ALU_DIVU  = 5'd18,
    ALU_REMU  = 5'd19,
    ALU_DIVW  = 5'd20,
    ALU_REMW  = 5'd21,
    ALU_DIVUW = 5'd22,
    ALU_REMUW = 5'd23
  } alufunc_t;
endpackage

module execute_div
  import execute_div_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alufunc,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int HALF = 32;
  localparam int CW   = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  function automatic logic [WIDTH-1:0] fmt_result(input logic [WIDTH-1:0] v, input logic is_w);
    return is_w ? {{(WIDTH-HALF){v[HALF-1]}}, v[HALF-1:0]} : v;
  endfunction

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_is_rem;
  logic             r_is_w;
  logic [WIDTH-1:0] r_result;
  logic             r_out_valid;

  logic w_is_div, w_is_rem, w_is_uns, w_is_w;

  // NOTE: every output of a combinational block gets a default first, otherwise
  // unlisted case items would infer latches.
  always_comb begin
    w_is_div = 1'b0;
    w_is_rem = 1'b0;
    w_is_uns = 1'b0;
    w_is_w   = 1'b0;
    case (alufunc)
      ALU_DIV:   w_is_div = 1'b1;
      ALU_REM:   begin w_is_div = 1'b1; w_is_rem = 1'b1; end
      ALU_DIVU:  begin w_is_div = 1'b1; w_is_uns = 1'b1; end
      ALU_REMU:  begin w_is_div = 1'b1; w_is_rem = 1'b1; w_is_uns = 1'b1; end
      ALU_DIVW:  begin w_is_div = 1'b1; w_is_w = 1'b1; end
      ALU_REMW:  begin w_is_div = 1'b1; w_is_rem = 1'b1; w_is_w = 1'b1; end
      ALU_DIVUW: begin w_is_div = 1'b1; w_is_uns = 1'b1; w_is_w = 1'b1; end
      ALU_REMUW: begin w_is_div = 1'b1; w_is_rem = 1'b1; w_is_uns = 1'b1; w_is_w = 1'b1; end
      default:   ;
    endcase
  end

  // Operand preparation: W ops see only the low word, extended per signedness.
  logic [WIDTH-1:0] w_a_prep, w_b_prep, w_a_abs, w_b_abs, w_min;
  logic             w_sa, w_sb, w_b_zero, w_ovf, w_special, w_accept;
  logic [WIDTH-1:0] w_spec_q, w_spec_r, w_spec_result;

  assign w_a_prep = !w_is_w  ? srca :
                    w_is_uns ? {{(WIDTH-HALF){1'b0}}, srca[HALF-1:0]} :
                               {{(WIDTH-HALF){srca[HALF-1]}}, srca[HALF-1:0]};
  assign w_b_prep = !w_is_w  ? srcb :
                    w_is_uns ? {{(WIDTH-HALF){1'b0}}, srcb[HALF-1:0]} :
                               {{(WIDTH-HALF){srcb[HALF-1]}}, srcb[HALF-1:0]};
  assign w_sa     = !w_is_uns && w_a_prep[WIDTH-1];
  assign w_sb     = !w_is_uns && w_b_prep[WIDTH-1];
  assign w_a_abs  = w_sa ? -w_a_prep : w_a_prep;
  assign w_b_abs  = w_sb ? -w_b_prep : w_b_prep;
  assign w_min    = w_is_w ? {{(WIDTH-HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                           : {1'b1, {(WIDTH-1){1'b0}}};

  assign w_b_zero  = (w_b_prep == '0);
  assign w_ovf     = !w_is_uns && (w_b_prep == '1) && (w_a_prep == w_min);
  assign w_special = w_b_zero || w_ovf;
  // On overflow the prepared dividend already equals MIN, the required quotient.
  assign w_spec_q      = w_b_zero ? '1 : w_a_prep;
  assign w_spec_r      = w_b_zero ? w_a_prep : '0;
  assign w_spec_result = fmt_result(w_is_rem ? w_spec_r : w_spec_q, w_is_w);

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid && in_ready && !flush && w_is_div;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [WIDTH:0]   w_rem_sh, w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_next;

  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_div};
  assign w_qbit     = !w_diff[WIDTH];
  assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];

  logic [WIDTH-1:0] w_q_fix, w_r_fix, w_fix_result;

  assign w_q_fix      = r_sign_q ? -r_quo : r_quo;
  assign w_r_fix      = r_sign_r ? -r_rem : r_rem;
  assign w_fix_result = fmt_result(r_is_rem ? w_r_fix : w_q_fix, r_is_w);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_is_rem    <= 1'b0;
      r_is_w      <= 1'b0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_special) begin
              r_result    <= w_spec_result;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              // W dividends sit in the top half so N=32 shifts leave the quotient low.
              r_quo    <= w_is_w ? {w_a_abs[HALF-1:0], {(WIDTH-HALF){1'b0}}} : w_a_abs;
              r_rem    <= '0;
              r_div    <= w_b_abs;
              r_cnt    <= w_is_w ? CW'(HALF-1) : CW'(WIDTH-1);
              r_sign_q <= w_sa ^ w_sb;
              r_sign_r <= w_sa;
              r_is_rem <= w_is_rem;
              r_is_w   <= w_is_w;
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result    <= w_fix_result;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule

// File: tb/tb_execute_div.sv
// Directed self-checking bench for execute_div: arithmetic, special cases,
// latency, back-pressure, flush and asynchronous reset.
module tb_execute_div;
  import execute_div_pkg::*;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  alufunc;
  logic [63:0] srca;
  logic [63:0] srcb;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;

  int n_checks = 0;
  int n_errors = 0;

  execute_div #(.WIDTH(64)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alufunc   (alufunc),
    .srca      (srca),
    .srcb      (srcb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts negedges after the accept edge until out_valid is seen (1 = first cycle).
  task automatic wait_result(output int lat, output logic [63:0] res);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    res = result;
  endtask

  task automatic do_op(input string tag, input logic [4:0] f, input logic [63:0] a,
                       input logic [63:0] b, output int lat, output logic [63:0] res);
    @(negedge clk);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    alufunc  = f;
    srca     = a;
    srcb     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(lat, res);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic [4:0] f, input logic [63:0] a,
                               input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    int          lat;
    logic [63:0] res;
    do_op(tag, f, a, b, lat, res);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, res, exp);
    release_result();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=no finish required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    int          seen;
    logic [63:0] res;

    resetn    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alufunc   = ALU_ADD;
    srca      = '0;
    srcb      = '0;
    #12;
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_result", result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Normal 64-bit operations.
    run_and_check("div_m7_2", ALU_DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    run_and_check("rem_m7_2", ALU_REM, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    run_and_check("remu_7_2", ALU_REMU, 64'd7, 64'd2, 64'd1, 66);

    // Special cases resolved at accept.
    run_and_check("divu_by0", ALU_DIVU, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_and_check("rem_by0", ALU_REM, 64'd5, 64'd0, 64'd5, 1);
    run_and_check("div_ovf", ALU_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h8000_0000_0000_0000, 1);
    run_and_check("remw_ovf", ALU_REMW, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);

    // W forms: 32 iterations and sign-extended results.
    run_and_check("divuw_max", ALU_DIVUW, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    run_and_check("divw_low", ALU_DIVW, 64'h1_0000_0010, 64'd4, 64'd4, 34);

    // Non-divide alufunc is ignored.
    @(negedge clk);
    in_valid = 1'b1;
    alufunc  = ALU_ADD;
    srca     = 64'd9;
    srcb     = 64'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("nondiv_in_ready", {63'd0, in_ready}, 64'd1);
    check("nondiv_out_valid", {63'd0, out_valid}, 64'd0);

    // Back-pressure: result held for 10 cycles with out_ready low.
    do_op("hold", ALU_DIVU, 64'd100, 64'd7, lat, res);
    check("hold_latency", 64'(lat), 64'd66);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_result", result, 64'd14);
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    // Release and present a new request in the same cycle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alufunc   = ALU_DIV;
    srca      = 64'd20;
    srcb      = 64'd3;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_in_ready", {63'd0, in_ready}, 64'd1);
    check("release_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("next_accept_in_ready", {63'd0, in_ready}, 64'd0);
    wait_result(lat, res);
    check("next_latency", 64'(lat), 64'd66);
    check("next_result", res, 64'd6);
    release_result();

    // Flush with in_valid blocks acceptance.
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    alufunc  = ALU_DIV;
    srca     = 64'd50;
    srcb     = 64'd5;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_block_in_ready", {63'd0, in_ready}, 64'd1);

    // Flush at CALC iteration 10.
    @(negedge clk);
    in_valid = 1'b1;
    alufunc  = ALU_DIV;
    srca     = 64'd1000;
    srcb     = 64'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush_no_out_valid", 64'(seen), 64'd0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    in_valid = 1'b1;
    alufunc  = ALU_DIV;
    srca     = 64'd77;
    srcb     = 64'd11;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("areset_out_valid", {63'd0, out_valid}, 64'd0);
    check("areset_result", result, 64'd0);
    check("areset_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("areset_no_out_valid", 64'(seen), 64'd0);
    run_and_check("after_reset_div", ALU_DIV, 64'd100, 64'd7, 64'd14, 66);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
